// File: rtl/timer_sync.sv
// DMG-style DIV/TIMA/TMA/TAC timer, fully synchronous: TIMA advances on a
// detected falling edge of the selected counter tap, with delayed TMA reload.
//
// state  | meaning
// RUN    | normal counting, TIMA increments on each tap falling edge
// OVF    | TIMA wrapped to 00, counting down the reload delay
// RELOAD | single cycle: TIMA holds TMA, timerIRQ high
module timer_sync #(
    parameter int unsigned DIV_WIDTH       = 16,
    parameter logic [15:0] BASE_ADDR       = 16'hFF04,
    parameter int unsigned TAP0            = 9,
    parameter int unsigned TAP1            = 3,
    parameter int unsigned TAP2            = 5,
    parameter int unsigned TAP3            = 7,
    parameter int unsigned RELOAD_DELAY    = 4,
    parameter bit          TAC_UNUSED_ONES = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] A_mmu,
    input  logic [7:0]  Di_mmu,
    output logic [7:0]  Do_mmu,
    input  logic        wr_mmu,
    input  logic        rd_mmu,
    input  logic        cs_mmu,
    output logic        timerIRQ
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        OVF    = 2'd1,
        RELOAD = 2'd2
    } state_t;

    localparam logic [15:0]          ADDR_TIMA = BASE_ADDR + 16'd1;
    localparam logic [15:0]          ADDR_TMA  = BASE_ADDR + 16'd2;
    localparam logic [15:0]          ADDR_TAC  = BASE_ADDR + 16'd3;
    localparam logic [3:0]           DLY_INIT  = 4'(RELOAD_DELAY - 1);
    localparam logic [DIV_WIDTH-1:0] CNT_ONE   = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    state_t               state, state_next;
    logic [DIV_WIDTH-1:0] cnt, cnt_next;
    logic [7:0]           tima, tima_next;
    logic [7:0]           tma, tma_next;
    logic [2:0]           tac, tac_next;
    logic [3:0]           dly, dly_next;
    logic                 t_prev, t_now, tap_bit, tick;
    logic                 wr_div, wr_tima, wr_tma, wr_tac;

    always_comb begin
        wr_div  = cs_mmu & wr_mmu & (A_mmu == BASE_ADDR);
        wr_tima = cs_mmu & wr_mmu & (A_mmu == ADDR_TIMA);
        wr_tma  = cs_mmu & wr_mmu & (A_mmu == ADDR_TMA);
        wr_tac  = cs_mmu & wr_mmu & (A_mmu == ADDR_TAC);

        cnt_next = wr_div ? '0 : cnt + CNT_ONE;
        tac_next = wr_tac ? Di_mmu[2:0] : tac;
        tma_next = wr_tma ? Di_mmu : tma;

        // Tap is taken from post-update values so DIV clears and TAC
        // changes can themselves produce a falling edge.
        case (tac_next[1:0])
            2'd0:    tap_bit = cnt_next[TAP0];
            2'd1:    tap_bit = cnt_next[TAP1];
            2'd2:    tap_bit = cnt_next[TAP2];
            default: tap_bit = cnt_next[TAP3];
        endcase
        t_now = tac_next[2] & tap_bit;
        tick  = t_prev & ~t_now;
    end

    always_comb begin
        state_next = state;
        tima_next  = tima;
        dly_next   = dly;
        unique case (state)
            RUN: begin
                if (wr_tima) begin
                    tima_next = Di_mmu;
                end else if (tick) begin
                    if (tima == 8'hFF) begin
                        tima_next  = 8'h00;
                        state_next = OVF;
                        dly_next   = DLY_INIT;
                    end else begin
                        tima_next = tima + 8'd1;
                    end
                end
            end
            OVF: begin
                if (wr_tima) begin
                    tima_next  = Di_mmu;
                    state_next = RUN;
                    dly_next   = '0;
                end else if (dly == '0) begin
                    tima_next  = tma_next;
                    state_next = RELOAD;
                end else begin
                    dly_next = dly - 4'd1;
                    if (tick) tima_next = tima + 8'd1;
                end
            end
            RELOAD: begin
                // TIMA follows TMA for the whole cycle; a TMA write lands here too
                tima_next  = tma_next;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RUN;
            cnt    <= '0;
            tima   <= '0;
            tma    <= '0;
            tac    <= '0;
            dly    <= '0;
            t_prev <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            tima   <= tima_next;
            tma    <= tma_next;
            tac    <= tac_next;
            dly    <= dly_next;
            t_prev <= t_now;
        end
    end

    assign timerIRQ = (state == RELOAD);

    always_comb begin
        Do_mmu = 8'h00;
        if (cs_mmu && rd_mmu) begin
            case (A_mmu)
                BASE_ADDR: Do_mmu = cnt[DIV_WIDTH-1 -: 8];
                ADDR_TIMA: Do_mmu = tima;
                ADDR_TMA:  Do_mmu = tma;
                ADDR_TAC:  Do_mmu = {{5{TAC_UNUSED_ONES}}, tac};
                default:   Do_mmu = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_sync.sv
// Bench for timer_sync: register table, directed overflow/cancel/reload
// sequences, then random bus traffic against an arithmetic reference model.
module tb_timer_sync;

    localparam int          DW     = 16;
    localparam int          RD     = 4;
    localparam logic [15:0] A_DIV  = 16'hFF04;
    localparam logic [15:0] A_TIMA = 16'hFF05;
    localparam logic [15:0] A_TMA  = 16'hFF06;
    localparam logic [15:0] A_TAC  = 16'hFF07;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] A_mmu = 16'h0000;
    logic [7:0]  Di_mmu = 8'h00;
    logic [7:0]  Do_mmu;
    logic        wr_mmu = 1'b0;
    logic        rd_mmu = 1'b0;
    logic        cs_mmu = 1'b0;
    logic        timerIRQ;

    timer_sync #(
        .DIV_WIDTH(16), .BASE_ADDR(16'hFF04), .TAP0(9), .TAP1(3), .TAP2(5),
        .TAP3(7), .RELOAD_DELAY(4), .TAC_UNUSED_ONES(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .A_mmu(A_mmu), .Di_mmu(Di_mmu),
        .Do_mmu(Do_mmu), .wr_mmu(wr_mmu), .rd_mmu(rd_mmu), .cs_mmu(cs_mmu),
        .timerIRQ(timerIRQ)
    );

    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] s_do;
    logic       s_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One bus cycle: drive just after a rising edge, sample at the falling edge.
    task automatic step(input bit w, input bit r, input bit c,
                        input logic [15:0] a, input logic [7:0] d);
        cs_mmu = c; wr_mmu = w; rd_mmu = r; A_mmu = a; Di_mmu = d;
        @(negedge clock);
        s_do  = Do_mmu;
        s_irq = timerIRQ;
        @(posedge clock);
        #1;
        wr_mmu = 1'b0; rd_mmu = 1'b0; cs_mmu = 1'b0;
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        step(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd_reg(input logic [15:0] a);
        step(1'b0, 1'b1, 1'b1, a, 8'h00);
    endtask

    task automatic do_reset();
        wr_mmu = 1'b0; rd_mmu = 1'b0; cs_mmu = 1'b0;
        #3 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    // Overflow setup: counter cleared, TIMA two ticks from wrapping on tap bit 3.
    task automatic setup_ovf();
        wr_reg(A_TAC, 8'h05);
        wr_reg(A_DIV, 8'h00);
        wr_reg(A_TMA, 8'h80);
        wr_reg(A_TIMA, 8'hFE);
    endtask

    task automatic find_ovf(input string name);
        int  k;
        bit  seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 64) begin
            k++;
            rd_reg(A_TIMA);
            if (s_do == 8'h00) seen = 1'b1;
        end
        chk(name, 32'(k), 32'd31);
    endtask

    // ---------------- reference model ----------------
    int m_cnt, m_tima, m_tma, m_tac, m_wait;
    bit m_tprev, m_rel;

    function automatic void m_reset();
        m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_wait = 0;
        m_tprev = 1'b0; m_rel = 1'b0;
    endfunction

    function automatic int tap_of(input int sel);
        case (sel)
            0:       return 9;
            1:       return 3;
            2:       return 5;
            default: return 7;
        endcase
    endfunction

    function automatic int m_read(input bit c, input bit r, input logic [15:0] a);
        if (!(c && r)) return 0;
        if (a == A_DIV)  return (m_cnt >> (DW - 8)) % 256;
        if (a == A_TIMA) return m_tima;
        if (a == A_TMA)  return m_tma;
        if (a == A_TAC)  return 248 + m_tac;
        return 0;
    endfunction

    // m_wait counts edges remaining until the reload edge; 0 means none pending.
    function automatic void m_step(input bit w, input logic [15:0] a, input logic [7:0] d);
        int n_cnt, n_tac, n_tma;
        bit t, tick;
        n_cnt = (w && a == A_DIV) ? 0 : (m_cnt + 1) % (1 << DW);
        n_tac = (w && a == A_TAC) ? int'(d) % 8 : m_tac;
        n_tma = (w && a == A_TMA) ? int'(d) : m_tma;
        t     = (n_tac >= 4) && (((n_cnt >> tap_of(n_tac % 4)) % 2) == 1);
        tick  = m_tprev && !t;
        if (m_rel) begin
            m_tima = n_tma;
            m_rel  = 1'b0;
        end else if (w && a == A_TIMA) begin
            m_tima = int'(d);
            m_wait = 0;
        end else if (m_wait == 1) begin
            m_tima = n_tma;
            m_rel  = 1'b1;
            m_wait = 0;
        end else begin
            if (m_wait > 1) m_wait--;
            if (tick) begin
                if (m_wait == 0 && m_tima == 255) begin
                    m_tima = 0;
                    m_wait = RD;
                end else begin
                    m_tima = (m_tima + 1) % 256;
                end
            end
        end
        m_cnt = n_cnt; m_tac = n_tac; m_tma = n_tma; m_tprev = t;
    endfunction

    typedef struct {
        bit          w;
        bit          r;
        bit          c;
        logic [15:0] a;
        logic [7:0]  d;
        bit          chk_do;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  first, last;
        bit  irq_seen, bad_val;

        tbl.push_back('{1'b0, 1'b1, 1'b1, A_TIMA,   8'h00, 1'b1, 8'h00, "rst_tima"});
        tbl.push_back('{1'b0, 1'b1, 1'b1, A_TMA,    8'h00, 1'b1, 8'h00, "rst_tma"});
        tbl.push_back('{1'b0, 1'b1, 1'b1, A_TAC,    8'h00, 1'b1, 8'hF8, "rst_tac"});
        tbl.push_back('{1'b0, 1'b1, 1'b1, A_DIV,    8'h00, 1'b1, 8'h00, "rst_div"});
        tbl.push_back('{1'b1, 1'b0, 1'b1, A_TMA,    8'h5A, 1'b0, 8'h00, "wr_tma"});
        tbl.push_back('{1'b0, 1'b1, 1'b1, A_TMA,    8'h00, 1'b1, 8'h5A, "rd_tma"});
        tbl.push_back('{1'b1, 1'b0, 1'b1, A_TIMA,   8'h12, 1'b0, 8'h00, "wr_tima"});
        tbl.push_back('{1'b0, 1'b1, 1'b1, A_TIMA,   8'h00, 1'b1, 8'h12, "rd_tima"});
        tbl.push_back('{1'b1, 1'b0, 1'b1, A_TAC,    8'hFF, 1'b0, 8'h00, "wr_tac_ff"});
        tbl.push_back('{1'b0, 1'b1, 1'b1, A_TAC,    8'h00, 1'b1, 8'hFF, "rd_tac_ff"});
        tbl.push_back('{1'b1, 1'b0, 1'b1, A_TAC,    8'h02, 1'b0, 8'h00, "wr_tac_02"});
        tbl.push_back('{1'b0, 1'b1, 1'b1, A_TAC,    8'h00, 1'b1, 8'hFA, "rd_tac_02"});
        tbl.push_back('{1'b0, 1'b1, 1'b0, A_TIMA,   8'h00, 1'b1, 8'h00, "cs_low"});
        tbl.push_back('{1'b0, 1'b0, 1'b1, A_TMA,    8'h00, 1'b1, 8'h00, "rd_low"});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 16'hFF08, 8'h00, 1'b1, 8'h00, "addr_above"});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 16'hFF03, 8'h00, 1'b1, 8'h00, "addr_below"});
        tbl.push_back('{1'b1, 1'b0, 1'b1, A_DIV,    8'h77, 1'b0, 8'h00, "wr_div"});
        tbl.push_back('{1'b0, 1'b1, 1'b1, A_DIV,    8'h00, 1'b1, 8'h00, "rd_div"});

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].a, tbl[i].d);
            if (tbl[i].chk_do) chk(tbl[i].name, 32'(s_do), 32'(tbl[i].exp));
            chk({tbl[i].name, "_irq"}, 32'(s_irq), 32'd0);
        end

        // overflow -> 4 cycles of 00 -> one RELOAD cycle with IRQ
        setup_ovf();
        find_ovf("ovf_latency");
        chk("ovf_first_irq", 32'(s_irq), 32'd0);
        for (int j = 0; j < 3; j++) begin
            rd_reg(A_TIMA);
            chk("ovf_hold_tima", 32'(s_do), 32'h00);
            chk("ovf_hold_irq", 32'(s_irq), 32'd0);
        end
        rd_reg(A_TIMA);
        chk("reload_tima", 32'(s_do), 32'h80);
        chk("reload_irq", 32'(s_irq), 32'd1);
        rd_reg(A_TIMA);
        chk("post_reload_tima", 32'(s_do), 32'h80);
        chk("post_reload_irq", 32'(s_irq), 32'd0);

        // TIMA write two clocks after overflow cancels the reload
        setup_ovf();
        find_ovf("ovf_latency_cancel");
        rd_reg(A_TIMA);
        wr_reg(A_TIMA, 8'h33);
        irq_seen = 1'b0; bad_val = 1'b0; first = 0; last = 0;
        for (int j = 0; j < 20; j++) begin
            rd_reg(A_TIMA);
            if (j == 0) first = int'(s_do);
            last = int'(s_do);
            if (s_irq) irq_seen = 1'b1;
            if (s_do != 8'h33 && s_do != 8'h34) bad_val = 1'b1;
        end
        chk("cancel_first", 32'(first), 32'h33);
        chk("cancel_last", 32'(last), 32'h34);
        chk("cancel_irq", 32'(irq_seen), 32'd0);
        chk("cancel_noreload", 32'(bad_val), 32'd0);

        // DIV write with tap high ticks; with tap low it does not
        wr_reg(A_TAC, 8'h05);
        wr_reg(A_DIV, 8'h00);
        wr_reg(A_TIMA, 8'h10);
        repeat (7) rd_reg(A_TIMA);
        wr_reg(A_DIV, 8'h00);
        rd_reg(A_TIMA);
        chk("div_clear_tick", 32'(s_do), 32'h11);
        wr_reg(A_DIV, 8'h00);
        rd_reg(A_TIMA);
        chk("div_clear_notick", 32'(s_do), 32'h11);

        // TAC mux change and TAC disable each tick
        wr_reg(A_TAC, 8'h05);
        wr_reg(A_DIV, 8'h00);
        wr_reg(A_TIMA, 8'h20);
        repeat (7) rd_reg(A_TIMA);
        wr_reg(A_TAC, 8'h04);
        rd_reg(A_TIMA);
        chk("tac_mux_tick", 32'(s_do), 32'h21);
        wr_reg(A_TAC, 8'h05);
        wr_reg(A_TAC, 8'h00);
        rd_reg(A_TIMA);
        chk("tac_disable_tick", 32'(s_do), 32'h22);

        // TMA write in the RELOAD cycle feeds TIMA
        setup_ovf();
        find_ovf("ovf_latency_tma");
        repeat (3) rd_reg(A_TIMA);
        wr_reg(A_TMA, 8'h55);
        chk("rl_tma_irq", 32'(s_irq), 32'd1);
        rd_reg(A_TIMA);
        chk("rl_tma_tima", 32'(s_do), 32'h55);
        chk("rl_tma_irq_off", 32'(s_irq), 32'd0);

        // TIMA write in the RELOAD cycle is ignored
        setup_ovf();
        find_ovf("ovf_latency_tima");
        repeat (3) rd_reg(A_TIMA);
        wr_reg(A_TIMA, 8'h11);
        chk("rl_tima_irq", 32'(s_irq), 32'd1);
        rd_reg(A_TIMA);
        chk("rl_tima_ignored", 32'(s_do), 32'h80);

        // reset mid-OVF: everything cleared, no IRQ afterwards
        setup_ovf();
        find_ovf("ovf_latency_rst");
        do_reset();
        rd_reg(A_TIMA);
        chk("rst_ovf_tima", 32'(s_do), 32'h00);
        rd_reg(A_TMA);
        chk("rst_ovf_tma", 32'(s_do), 32'h00);
        rd_reg(A_TAC);
        chk("rst_ovf_tac", 32'(s_do), 32'hF8);
        rd_reg(A_DIV);
        chk("rst_ovf_div", 32'(s_do), 32'h00);
        irq_seen = 1'b0;
        for (int j = 0; j < 20; j++) begin
            rd_reg(A_TIMA);
            if (s_irq) irq_seen = 1'b1;
        end
        chk("rst_ovf_noirq", 32'(irq_seen), 32'd0);

        // random bus traffic against the reference model
        do_reset();
        m_reset();
        for (int i = 0; i < 4000; i++) begin
            bit          w, r, c, dense;
            int          k;
            logic [15:0] a;
            logic [7:0]  d;
            dense = ((i / 500) % 2) == 0;
            w = dense ? ($urandom % 6 == 0) : ($urandom % 40 == 0);
            r = ($urandom % 4 != 0);
            c = ($urandom % 8 != 0);
            k = int'($urandom % 16);
            d = 8'($urandom);
            if (k == 0) a = A_DIV;
            else if (k <= 5) begin
                a = A_TIMA;
                if ($urandom % 4 != 0) d = 8'hFC | (d & 8'h03);
            end else if (k <= 8) a = A_TMA;
            else if (k == 9) begin
                a = A_TAC;
                if ($urandom % 4 != 0) d = (d & 8'hF8) | 8'h05;
            end else a = 16'($urandom);
            cs_mmu = c; wr_mmu = w; rd_mmu = r; A_mmu = a; Di_mmu = d;
            @(negedge clock);
            chk("rand_do", 32'(Do_mmu), 32'(m_read(c, r, a)));
            chk("rand_irq", 32'(timerIRQ), m_rel ? 32'd1 : 32'd0);
            @(posedge clock);
            m_step(w && c, a, d);
            #1;
        end
        wr_mmu = 1'b0; rd_mmu = 1'b0; cs_mmu = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_sync.md
Name: timer_sync

Overview:
Parametrised successor to the Game Boy DIV/TIMA/TMA/TAC timer. It is fully synchronous: there are no derived clocks, and TIMA increments on a detected falling edge of the selected prescaler tap. It models the DMG overflow reload delay, write-cancel behaviour and a single-cycle IRQ pulse. It sits on the MMU bus beside the other I/O registers and drives the timer request into the interrupt controller.

Parameters:
DIV_WIDTH, 16, width of the internal system counter (min 10, max 16). DIV reads its top 8 bits.
BASE_ADDR, 16'hFF04, address of DIV. TIMA, TMA and TAC follow at +1, +2 and +3.
TAP0, 9, counter bit used when TAC[1:0]=00.
TAP1, 3, counter bit used when TAC[1:0]=01.
TAP2, 5, counter bit used when TAC[1:0]=10.
TAP3, 7, counter bit used when TAC[1:0]=11.
RELOAD_DELAY, 4, clocks from TIMA overflow to the TMA reload and IRQ (range 1..15).
TAC_UNUSED_ONES, 1, when 1, TAC reads return bits [7:3] as 1.

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset_n  input  1  asynchronous, active-low reset
A_mmu  input  16  bus address
Di_mmu  input  8  bus write data
Do_mmu  output  8  bus read data (combinational)
wr_mmu  input  1  write strobe; one write per cycle while high
rd_mmu  input  1  read strobe
cs_mmu  input  1  chip select
timerIRQ  output  1  one-clock interrupt request pulse

Behaviour:
- Reset (reset_n low, asynchronous): counter, TIMA, TMA and TAC are 0; state is RUN; delay count is 0; timerIRQ is 0; no edge is pending. The edge-detect register is cleared to 0 so that the first cycle after reset cannot produce an increment.
- Counter:
  - Increments by 1 every clock and wraps modulo 2^DIV_WIDTH.
  - Any write to BASE_ADDR clears it to 0 in that cycle instead of incrementing.
- Tap signal: t = TAC[2] AND counter[TAPn], where n = TAC[1:0]. The signal is evaluated on post-update values, and t_prev is registered every clock.
- Tick: asserted when t_prev=1 and t=0.
  - A DIV clear, a TAC enable clear or a TAC mux change can each produce a tick. This is intentional DMG behaviour.
- TIMA increment: on a tick in RUN, TIMA increments by 1. If TIMA was FF, it becomes 00 and the state moves to OVF with delay count = RELOAD_DELAY-1.
- OVF state:
  - TIMA reads 00.
  - Ticks increment TIMA normally, from 00.
  - The delay count decrements each clock. When it reaches 0, the state moves to RELOAD.
  - A CPU write to TIMA during OVF loads Di_mmu, cancels the pending reload and IRQ, and returns the state to RUN.
- RELOAD state (exactly 1 clock):
  - TIMA loads TMA; timerIRQ is 1; the state returns to RUN on the next clock.
  - A CPU write to TIMA in this cycle is ignored.
  - A CPU write to TMA in this cycle is used for the load: TIMA takes Di_mmu.
  - A tick in this cycle is dropped.
- Write to TIMA in RUN: TIMA takes Di_mmu. A tick in the same cycle is dropped, so the write wins.
- TMA and TAC: written from Di_mmu, with TAC keeping bits [2:0] only. Writes to TMA and TAC do not disturb the counter.
- Reads: Do_mmu is 0 unless cs_mmu and rd_mmu are both high. Read values by address:
  - DIV returns counter[DIV_WIDTH-1 -: 8].
  - TIMA returns TIMA.
  - TMA returns TMA.
  - TAC returns {5{TAC_UNUSED_ONES}, TAC[2:0]}.
  - Any other address returns 0.
  - Reads have no side effects.
- timerIRQ is high only in the RELOAD cycle and is never held.
- Timing from overflow: the tick that overflows at edge k gives RELOAD (TIMA=TMA, IRQ=1) visible after edge k+RELOAD_DELAY.

Test Plan:
- Reset, then TAC=05 (tap bit 3), TIMA=FE, TMA=0x80. After 2 ticks (32 clocks), TIMA reads 00 for 4 clocks, then reads 0x80 with timerIRQ high for exactly 1 clock.
- Overflow, then TIMA write of 0x33 two clocks later: TIMA=0x33, no IRQ and no reload within 20 clocks.
- TAC=05 with counter bit 3 high, then DIV write: TIMA increments by 1 immediately. With counter bit 3 low, the same write gives no increment.
- TAC changed from 05 to 04 while counter bit 3=1 and bit 9=0: TIMA increments by 1. TAC changed to 00 while the tap is high: TIMA increments by 1.
- Write TMA=0x55 in the RELOAD cycle: TIMA=0x55 and IRQ pulses. A TIMA write of 0x11 in the RELOAD cycle is ignored and TIMA=TMA.
- Reads: TAC written 0xFF reads 0xFF, and TAC written 0x02 reads 0xFA. A read with cs_mmu=0 returns 00. A reset_n pulse mid-OVF clears everything and produces no IRQ.
